// File: rtl/tt_ternary_seq_ctrl.sv
// Sequencer for the ternary matrix-vector datapath: drives the weight loader through its
// columns and the multiplier through its output rows, and aligns the output-valid stream.
module tt_ternary_seq_ctrl #(
    parameter int unsigned MAX_IN_LEN  = 16,
    parameter int unsigned MAX_OUT_LEN = 8,
    parameter int unsigned MULT_LAT    = 1,
    parameter int unsigned CNT_W       = 8,
    localparam int unsigned COL_W      = $clog2(MAX_IN_LEN),
    localparam int unsigned ROW_W      = $clog2(MAX_OUT_LEN)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    input  logic [1:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_len,
    output logic             cmd_ready,
    input  logic             in_valid,
    output logic             load_en,
    output logic [COL_W-1:0] load_col,
    output logic             mult_en,
    output logic [ROW_W-1:0] mult_row,
    output logic             out_valid,
    output logic [ROW_W-1:0] out_row,
    output logic             out_last,
    output logic             weights_ok,
    output logic             busy,
    output logic             cmd_err
);

    localparam int unsigned DRN_W  = $clog2(MULT_LAT + 1);
    localparam int unsigned STG_W  = ROW_W + 2;
    localparam int unsigned PIPE_W = MULT_LAT * STG_W;

    localparam logic [1:0] OP_LOAD  = 2'b01;
    localparam logic [1:0] OP_RUN   = 2'b10;
    localparam logic [1:0] OP_ABORT = 2'b11;

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(MAX_IN_LEN - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(MAX_OUT_LEN - 1);
    localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'(MULT_LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_RUN   = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t             state, state_d;
    logic [COL_W-1:0]   col, col_d;
    logic [ROW_W-1:0]   row, row_d;
    logic [CNT_W-1:0]   vec, vec_d;
    logic [CNT_W-1:0]   len, len_d;
    logic [DRN_W-1:0]   dcnt, dcnt_d;
    logic               wok_d;
    logic               err_d;
    logic               abort;
    logic               last_beat;
    logic               push_vld;
    logic               push_last;
    logic [STG_W-1:0]   push_stage;
    logic [PIPE_W-1:0]  pipe;
    logic [STG_W-1:0]   pipe_out;

    assign abort     = cmd_valid && (cmd_op == OP_ABORT);
    // Final row of final vector; a zero length never terminates
    assign last_beat = (len != '0) && (row == ROW_LAST) && (vec == len - CNT_W'(1));

    assign cmd_ready = (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign load_col  = (state == S_LOAD) ? col : '0;
    assign mult_row  = (state == S_RUN)  ? row : '0;

    // Next-state, counter updates and enables
    always_comb begin
        state_d   = state;
        col_d     = col;
        row_d     = row;
        vec_d     = vec;
        len_d     = len;
        dcnt_d    = dcnt;
        wok_d     = weights_ok;
        err_d     = 1'b0;
        push_vld  = 1'b0;
        push_last = 1'b0;
        load_en   = 1'b0;
        mult_en   = 1'b0;

        case (state)
            S_IDLE: begin
                if (cmd_valid && (cmd_op == OP_LOAD)) begin
                    state_d = S_LOAD;
                    col_d   = '0;
                    wok_d   = 1'b0;
                end else if (cmd_valid && (cmd_op == OP_RUN)) begin
                    if (weights_ok) begin
                        state_d = S_RUN;
                        row_d   = '0;
                        vec_d   = '0;
                        len_d   = cmd_len;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_LOAD: begin
                load_en = in_valid;
                if (in_valid) begin
                    col_d = col + COL_W'(1);
                    if (col == COL_LAST) begin
                        wok_d   = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            S_RUN: begin
                mult_en = in_valid;
                if (in_valid) begin
                    push_vld  = 1'b1;
                    push_last = last_beat;
                    if (row == ROW_LAST) begin
                        row_d = '0;
                        vec_d = vec + CNT_W'(1);
                    end else begin
                        row_d = row + ROW_W'(1);
                    end
                    if (last_beat) begin
                        state_d = S_DRAIN;
                        dcnt_d  = '0;
                    end
                end
            end
            S_DRAIN: begin
                dcnt_d = dcnt + DRN_W'(1);
                if (dcnt == DRN_LAST) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if ((state != S_IDLE) && cmd_valid && ((cmd_op == OP_LOAD) || (cmd_op == OP_RUN))) begin
            err_d = 1'b1;
        end

        // Abort overrides every other event in the same cycle
        if (abort) begin
            state_d   = S_IDLE;
            push_vld  = 1'b0;
            push_last = 1'b0;
            if (state == S_LOAD) begin
                wok_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            col        <= '0;
            row        <= '0;
            vec        <= '0;
            len        <= '0;
            dcnt       <= '0;
            weights_ok <= 1'b0;
            cmd_err    <= 1'b0;
        end else begin
            state      <= state_d;
            col        <= col_d;
            row        <= row_d;
            vec        <= vec_d;
            len        <= len_d;
            dcnt       <= dcnt_d;
            weights_ok <= wok_d;
            cmd_err    <= err_d;
        end
    end

    // Output delay line: stages of {valid, last, row}, newest in the low slot
    assign push_stage = {push_vld, push_last, push_vld ? row : ROW_W'(0)};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe <= '0;
        end else if (abort) begin
            pipe <= '0;
        end else begin
            pipe <= (pipe << STG_W) | PIPE_W'(push_stage);
        end
    end

    assign pipe_out  = pipe[PIPE_W-1 -: STG_W];
    assign out_valid = pipe_out[STG_W-1];
    assign out_last  = pipe_out[STG_W-2];
    assign out_row   = pipe_out[ROW_W-1:0];

endmodule

// File: tb/tb_tt_ternary_seq_ctrl.sv
// Bench for tt_ternary_seq_ctrl: directed scenarios plus random command/beat traffic,
// compared each cycle against a beat-counting reference model.
module tb_tt_ternary_seq_ctrl;

    localparam int unsigned MAX_IN_LEN  = 16;
    localparam int unsigned MAX_OUT_LEN = 8;
    localparam int unsigned MULT_LAT    = 1;
    localparam int unsigned CNT_W       = 8;
    localparam int unsigned COL_W       = $clog2(MAX_IN_LEN);
    localparam int unsigned ROW_W       = $clog2(MAX_OUT_LEN);

    localparam logic [1:0] OP_NOP   = 2'b00;
    localparam logic [1:0] OP_LOAD  = 2'b01;
    localparam logic [1:0] OP_RUN   = 2'b10;
    localparam logic [1:0] OP_ABORT = 2'b11;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             cmd_valid = 1'b0;
    logic [1:0]       cmd_op = 2'b00;
    logic [CNT_W-1:0] cmd_len = '0;
    logic             cmd_ready;
    logic             in_valid = 1'b0;
    logic             load_en;
    logic [COL_W-1:0] load_col;
    logic             mult_en;
    logic [ROW_W-1:0] mult_row;
    logic             out_valid;
    logic [ROW_W-1:0] out_row;
    logic             out_last;
    logic             weights_ok;
    logic             busy;
    logic             cmd_err;

    tt_ternary_seq_ctrl #(
        .MAX_IN_LEN (MAX_IN_LEN),
        .MAX_OUT_LEN(MAX_OUT_LEN),
        .MULT_LAT   (MULT_LAT),
        .CNT_W      (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_op    (cmd_op),
        .cmd_len   (cmd_len),
        .cmd_ready (cmd_ready),
        .in_valid  (in_valid),
        .load_en   (load_en),
        .load_col  (load_col),
        .mult_en   (mult_en),
        .mult_row  (mult_row),
        .out_valid (out_valid),
        .out_row   (out_row),
        .out_last  (out_last),
        .weights_ok(weights_ok),
        .busy      (busy),
        .cmd_err   (cmd_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: activity mode plus a count of accepted beats in the current operation
    typedef enum int {M_IDLE, M_LOAD, M_RUN, M_DRAIN} mode_t;
    typedef struct {
        bit vld;
        int row;
        bit last;
    } ent_t;

    mode_t mode;
    int    n;
    int    run_len;
    int    dcount;
    bit    wok;
    bit    err;
    ent_t  pipe_q[$];

    function automatic ent_t empty_ent();
        ent_t e;
        e.vld  = 1'b0;
        e.row  = 0;
        e.last = 1'b0;
        return e;
    endfunction

    task automatic model_reset();
        mode    = M_IDLE;
        n       = 0;
        run_len = 0;
        dcount  = 0;
        wok     = 1'b0;
        err     = 1'b0;
        pipe_q.delete();
        for (int i = 0; i < int'(MULT_LAT); i++) pipe_q.push_back(empty_ent());
    endtask

    task automatic check_outputs(input bit iv);
        check("cmd_ready",  32'(cmd_ready),  32'(mode == M_IDLE));
        check("busy",       32'(busy),       32'(mode != M_IDLE));
        check("load_en",    32'(load_en),    32'(mode == M_LOAD && iv));
        check("load_col",   32'(load_col),   (mode == M_LOAD) ? 32'(n) : 32'd0);
        check("mult_en",    32'(mult_en),    32'(mode == M_RUN && iv));
        check("mult_row",   32'(mult_row),   (mode == M_RUN) ? 32'(n % int'(MAX_OUT_LEN)) : 32'd0);
        check("out_valid",  32'(out_valid),  32'(pipe_q[0].vld));
        check("out_row",    32'(out_row),    32'(pipe_q[0].row));
        check("out_last",   32'(out_last),   32'(pipe_q[0].last));
        check("weights_ok", 32'(weights_ok), 32'(wok));
        check("cmd_err",    32'(cmd_err),    32'(err));
    endtask

    task automatic model_update(input bit cv, input logic [1:0] op, input int len, input bit iv);
        bit   ab;
        ent_t e;
        ab = cv && (op == OP_ABORT);
        e  = empty_ent();
        if (mode == M_RUN && iv && !ab) begin
            e.vld  = 1'b1;
            e.row  = n % int'(MAX_OUT_LEN);
            e.last = (run_len != 0) && (n == run_len * int'(MAX_OUT_LEN) - 1);
        end
        void'(pipe_q.pop_front());
        pipe_q.push_back(e);
        if (ab) foreach (pipe_q[i]) pipe_q[i] = empty_ent();

        err = cv && ((mode == M_IDLE && op == OP_RUN && !wok) ||
                     (mode != M_IDLE && (op == OP_LOAD || op == OP_RUN)));

        if (ab) begin
            if (mode == M_LOAD) wok = 1'b0;
            mode = M_IDLE;
        end else begin
            case (mode)
                M_IDLE: begin
                    if (cv && op == OP_LOAD) begin
                        mode = M_LOAD; n = 0; wok = 1'b0;
                    end else if (cv && op == OP_RUN && wok) begin
                        mode = M_RUN; n = 0; run_len = len;
                    end
                end
                M_LOAD: if (iv) begin
                    n++;
                    if (n == int'(MAX_IN_LEN)) begin
                        wok = 1'b1; mode = M_IDLE;
                    end
                end
                M_RUN: if (iv) begin
                    n++;
                    if (run_len != 0 && n == run_len * int'(MAX_OUT_LEN)) begin
                        mode = M_DRAIN; dcount = 0;
                    end
                end
                M_DRAIN: begin
                    dcount++;
                    if (dcount == int'(MULT_LAT)) mode = M_IDLE;
                end
                default: mode = M_IDLE;
            endcase
        end
    endtask

    // One clock cycle: drive inputs on the falling edge, check, advance the model, take the edge
    task automatic step(input bit cv, input logic [1:0] op, input int len, input bit iv);
        @(negedge clk);
        cmd_valid = cv;
        cmd_op    = op;
        cmd_len   = CNT_W'(len);
        in_valid  = iv;
        #1;
        check_outputs(iv);
        model_update(cv, op, len, iv);
        @(posedge clk);
    endtask

    task automatic pulse_reset();
        #2;
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        in_valid  = 1'b0;
        #1;
        check("rst_cmd_ready",  32'(cmd_ready),  32'd1);
        check("rst_busy",       32'(busy),       32'd0);
        check("rst_load_en",    32'(load_en),    32'd0);
        check("rst_load_col",   32'(load_col),   32'd0);
        check("rst_mult_en",    32'(mult_en),    32'd0);
        check("rst_mult_row",   32'(mult_row),   32'd0);
        check("rst_out_valid",  32'(out_valid),  32'd0);
        check("rst_out_row",    32'(out_row),    32'd0);
        check("rst_out_last",   32'(out_last),   32'd0);
        check("rst_weights_ok", 32'(weights_ok), 32'd0);
        check("rst_cmd_err",    32'(cmd_err),    32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic full_load();
        step(1'b1, OP_LOAD, 0, 1'b0);
        repeat (MAX_IN_LEN) step(1'b0, OP_NOP, 0, 1'b1);
    endtask

    initial begin
        model_reset();
        pulse_reset();

        // RUN before any LOAD is rejected
        step(1'b1, OP_RUN, 2, 1'b1);
        repeat (3) step(1'b0, OP_NOP, 0, 1'b1);

        // Uninterrupted LOAD
        step(1'b1, OP_LOAD, 0, 1'b0);
        repeat (MAX_IN_LEN) step(1'b0, OP_NOP, 0, 1'b1);
        repeat (2) step(1'b0, OP_NOP, 0, 1'b0);

        // LOAD with alternating beats
        step(1'b1, OP_LOAD, 0, 1'b0);
        for (int i = 0; i < 32; i++) step(1'b0, OP_NOP, 0, (i % 2) == 0);
        step(1'b0, OP_NOP, 0, 1'b0);

        // RUN of two vectors, back to back
        step(1'b1, OP_RUN, 2, 1'b1);
        repeat (16) step(1'b0, OP_NOP, 0, 1'b1);
        repeat (3) step(1'b0, OP_NOP, 0, 1'b0);

        // Endless RUN stopped by ABORT, with a rejected command mid-run
        step(1'b1, OP_RUN, 0, 1'b0);
        for (int i = 0; i < 40; i++) step(i == 20, OP_LOAD, 0, 1'b1);
        step(1'b1, OP_ABORT, 0, 1'b1);
        repeat (2) step(1'b0, OP_NOP, 0, 1'b1);

        // ABORT in IDLE is a no-op
        step(1'b1, OP_ABORT, 0, 1'b0);
        step(1'b0, OP_NOP, 0, 1'b0);

        // ABORT partway through LOAD, then RUN is refused
        step(1'b1, OP_LOAD, 0, 1'b0);
        repeat (9) step(1'b0, OP_NOP, 0, 1'b1);
        step(1'b1, OP_ABORT, 0, 1'b1);
        step(1'b1, OP_RUN, 1, 1'b0);
        repeat (2) step(1'b0, OP_NOP, 0, 1'b0);

        // Reset in the middle of a RUN
        full_load();
        step(1'b1, OP_RUN, 3, 1'b0);
        repeat (11) step(1'b0, OP_NOP, 0, 1'b1);
        pulse_reset();
        step(1'b0, OP_NOP, 0, 1'b0);

        // Random command and beat traffic
        full_load();
        for (int c = 0; c < 3000; c++) begin
            bit         cv;
            logic [1:0] op;
            int         len;
            bit         iv;
            int         r;
            iv  = ($urandom % 4) != 0;
            len = int'($urandom % 4);
            if (mode == M_IDLE) begin
                cv = ($urandom % 3) == 0;
                op = 2'($urandom % 4);
            end else begin
                r  = int'($urandom % 64);
                cv = r < 2;
                op = (r == 0) ? OP_ABORT : 2'(1 + ($urandom % 2));
            end
            if (($urandom % 800) == 0) begin
                pulse_reset();
            end else begin
                step(cv, op, len, iv);
            end
        end
        repeat (4) step(1'b1, OP_ABORT, 0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
